// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divide issue/writeback controller.
package div_issue_ctrl_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_W    = 4;
    localparam int DIV_LAT  = 2;

    // One in-flight divide: valid, will write back, destination register.
    typedef struct packed {
        logic             v;
        logic             wb;
        logic [REG_W-1:0] rd;
    } slot_t;

    // One-hot register mask for a register address.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

    // Pending-write mask contributed by one slot.
    function automatic logic [NUM_REGS-1:0] slot_mask(input slot_t s);
        return (s.v && s.wb) ? reg_onehot(s.rd) : '0;
    endfunction

endpackage

// File: rtl/div_hazard_check.sv
// Read-after-write hazard detection against divides still in the datapath.
module div_hazard_check
    import div_issue_ctrl_pkg::*;
(
    input  slot_t            slot0,
    input  slot_t            slot1,
    input  logic             use_rn,
    input  logic [REG_W-1:0] rn,
    input  logic [REG_W-1:0] rm,
    input  logic [REG_W-1:0] rs,
    output logic             hazard
);

    logic [NUM_REGS-1:0] pending;

    // Stall if any source read by the offered op is still awaiting its divide result.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path,
        // otherwise synthesis infers a latch to hold the old value.
        pending = slot_mask(slot0) | slot_mask(slot1);
        hazard  = pending[rm] | pending[rs] | (use_rn & pending[rn]);
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue and writeback controller for the fixed-latency divide datapath.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_A,
    input  logic             REQ_S,
    input  logic             REQ_WB,
    input  logic [REG_W-1:0] REQ_RN,
    input  logic [REG_W-1:0] REQ_RM,
    input  logic [REG_W-1:0] REQ_RS,
    input  logic [REG_W-1:0] REQ_RD,
    input  logic [31:0]      REQ_DIVISOR,
    input  logic             FLUSH,
    output logic             ISS_A,
    output logic             ISS_S,
    output logic             ISS_WB,
    output logic [REG_W-1:0] ISS_RD,
    input  logic             DIV_WB_IN,
    input  logic [REG_W-1:0] DIV_ADDR_IN,
    output logic             WB_EN,
    output logic [REG_W-1:0] WB_ADDR,
    output logic [NUM_REGS-1:0] BUSY_MASK,
    output logic             DZ_FAULT,
    output logic             ADDR_ERR,
    output logic [CNT_W-1:0] ISSUE_CNT
);

    slot_t slot0;
    slot_t slot1;
    logic  hazard;
    logic  fire;
    logic  div_zero;
    logic  ret_hit;
    logic  ret_mismatch;
    logic  ret_orphan;
    logic  flush_d1;
    logic  flush_d2;

    // The slot register only models a fixed DIV_LAT-cycle datapath.
    lat_fixed: assert property (@(posedge CLK) LAT == DIV_LAT);

    div_hazard_check u_hazard (
        .slot0  (slot0),
        .slot1  (slot1),
        .use_rn (REQ_A),
        .rn     (REQ_RN),
        .rm     (REQ_RM),
        .rs     (REQ_RS),
        .hazard (hazard)
    );

    // Handshake and issue controls, valid only in the firing cycle.
    always_comb begin
        REQ_READY = ~RST & ~FLUSH & ~hazard;
        fire      = REQ_VALID & REQ_READY;
        div_zero  = (REQ_DIVISOR == 32'd0);
        ISS_A     = fire & REQ_A;
        ISS_S     = fire & REQ_S;
        ISS_WB    = fire & REQ_WB & ~div_zero;
        ISS_RD    = fire ? REQ_RD : '0;
    end

    // Track each issued op until its result returns; flush or reset empties the pipe.
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignment so slot1 samples the
        // old slot0 value rather than the one written in this same edge.
        if (RST) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            slot0   <= '{v: fire, wb: ISS_WB, rd: ISS_RD};
            slot1   <= slot0;
            slot1.v <= slot0.v & ~FLUSH;
        end
    end

    // Writeback gating and consistency checks on the returning result.
    always_comb begin
        ret_hit      = slot1.v & slot1.wb & DIV_WB_IN;
        ret_mismatch = ret_hit & (DIV_ADDR_IN != slot1.rd);
        ret_orphan   = DIV_WB_IN & ~slot1.v & ~flush_d1 & ~flush_d2;
        WB_EN        = ret_hit & ~RST;
        WB_ADDR      = WB_EN ? slot1.rd : '0;
        BUSY_MASK    = slot_mask(slot0) | slot_mask(slot1);
    end

    // Flush history, fault pulse, sticky address error and saturating issue count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            flush_d1  <= 1'b0;
            flush_d2  <= 1'b0;
            DZ_FAULT  <= 1'b0;
            ADDR_ERR  <= 1'b0;
            ISSUE_CNT <= '0;
        end else begin
            flush_d1 <= FLUSH;
            flush_d2 <= flush_d1;
            DZ_FAULT <= fire & div_zero;
            ADDR_ERR <= ADDR_ERR | ret_mismatch | ret_orphan;
            if (fire && (ISSUE_CNT != '1)) begin
                ISSUE_CNT <= ISSUE_CNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: op-list model plus directed literal checks.
module tb_div_issue_ctrl;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic        req_a, req_s, req_wb;
    logic [3:0]  req_rn, req_rm, req_rs, req_rd;
    logic [31:0] req_divisor;
    logic        flush;
    logic        iss_a, iss_s, iss_wb;
    logic [3:0]  iss_rd;
    logic        div_wb_in;
    logic [3:0]  div_addr_in;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] busy_mask;
    logic        dz_fault, addr_err;
    logic [CNT_W-1:0] issue_cnt;

    // datapath stand-in: two-stage delay of the issue outputs, overridable
    logic        dp1_wb, dp2_wb;
    logic [3:0]  dp1_rd, dp2_rd;
    logic        ovr_en, ovr_wb;
    logic [3:0]  ovr_addr;

    int n_cmp  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.LAT(2), .CNT_W(CNT_W)) dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_A(req_a), .REQ_S(req_s), .REQ_WB(req_wb),
        .REQ_RN(req_rn), .REQ_RM(req_rm), .REQ_RS(req_rs), .REQ_RD(req_rd),
        .REQ_DIVISOR(req_divisor), .FLUSH(flush),
        .ISS_A(iss_a), .ISS_S(iss_s), .ISS_WB(iss_wb), .ISS_RD(iss_rd),
        .DIV_WB_IN(div_wb_in), .DIV_ADDR_IN(div_addr_in),
        .WB_EN(wb_en), .WB_ADDR(wb_addr), .BUSY_MASK(busy_mask),
        .DZ_FAULT(dz_fault), .ADDR_ERR(addr_err), .ISSUE_CNT(issue_cnt)
    );

    always @(posedge clk) begin
        if (rst) begin
            dp1_wb <= 1'b0; dp1_rd <= '0;
            dp2_wb <= 1'b0; dp2_rd <= '0;
        end else begin
            dp1_wb <= iss_wb; dp1_rd <= iss_rd;
            dp2_wb <= dp1_wb; dp2_rd <= dp1_rd;
        end
    end

    assign div_wb_in   = ovr_en ? ovr_wb   : dp2_wb;
    assign div_addr_in = ovr_en ? ovr_addr : dp2_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         issue;
        logic       wb;
        logic [3:0] rd;
    } op_t;

    op_t         ops[$];
    int          cyc        = 0;
    int          last_flush = -100;
    logic        m_dz       = 1'b0;
    logic        m_err      = 1'b0;
    int          m_cnt      = 0;
    logic [15:0] e_busy;
    logic        e_ready, e_fire, e_wb_en, has_ret, ret_wb;
    logic [3:0]  ret_rd;
    int          age;

    always @(negedge clk) begin
        if (checking) begin
            e_busy  = '0;
            has_ret = 1'b0;
            ret_wb  = 1'b0;
            ret_rd  = '0;
            foreach (ops[i]) begin
                age = cyc - ops[i].issue;
                if (ops[i].wb && (age == 1 || age == 2)) e_busy[ops[i].rd] = 1'b1;
                if (age == 2) begin
                    has_ret = 1'b1;
                    ret_wb  = ops[i].wb;
                    ret_rd  = ops[i].rd;
                end
            end
            e_ready = !rst && !flush && !e_busy[req_rm] && !e_busy[req_rs]
                      && !(req_a && e_busy[req_rn]);
            e_fire  = req_valid && e_ready;
            e_wb_en = !rst && has_ret && ret_wb && div_wb_in;

            check("req_ready", 32'(req_ready), 32'(e_ready));
            check("iss_a",     32'(iss_a),     32'(e_fire && req_a));
            check("iss_s",     32'(iss_s),     32'(e_fire && req_s));
            check("iss_wb",    32'(iss_wb),    32'(e_fire && req_wb && req_divisor != 0));
            check("iss_rd",    32'(iss_rd),    e_fire ? 32'(req_rd) : 32'd0);
            check("wb_en",     32'(wb_en),     32'(e_wb_en));
            check("wb_addr",   32'(wb_addr),   e_wb_en ? 32'(ret_rd) : 32'd0);
            check("busy_mask", 32'(busy_mask), 32'(e_busy));
            check("dz_fault",  32'(dz_fault),  32'(m_dz));
            check("addr_err",  32'(addr_err),  32'(m_err));
            check("issue_cnt", 32'(issue_cnt), 32'(m_cnt));

            // end-of-cycle state update
            if (rst) begin
                m_err = 1'b0; m_dz = 1'b0; m_cnt = 0;
                ops.delete();
                last_flush = -100;
            end else begin
                if (has_ret && ret_wb && div_wb_in && div_addr_in != ret_rd) m_err = 1'b1;
                if (div_wb_in && !has_ret && (cyc - last_flush) > 2) m_err = 1'b1;
                m_dz = e_fire && req_divisor == 0;
                if (e_fire && m_cnt < (2**CNT_W - 1)) m_cnt++;
                if (e_fire) ops.push_back('{issue: cyc, wb: req_wb && req_divisor != 0, rd: req_rd});
                if (flush) begin
                    ops.delete();
                    last_flush = cyc;
                end
            end
            for (int i = ops.size() - 1; i >= 0; i--) begin
                if (cyc - ops[i].issue >= 2) ops.delete(i);
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic a, input logic wb, input logic [3:0] rn, input logic [3:0] rm,
                         input logic [3:0] rs, input logic [3:0] rd, input logic [31:0] dv);
        req_valid = 1'b1; req_a = a; req_s = rd[0]; req_wb = wb;
        req_rn = rn; req_rm = rm; req_rs = rs; req_rd = rd; req_divisor = dv;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0;
        req_a = 1'b0; req_s = 1'b0; req_wb = 1'b0;
        req_rn = '0; req_rm = '0; req_rs = '0; req_rd = '0; req_divisor = '0;
        ovr_en = 1'b0; ovr_wb = 1'b0; ovr_addr = '0;

        // reset state
        step();
        checking = 1'b1;
        @(negedge clk);
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst busy",  32'(busy_mask), 32'd0);
        check("rst cnt",   32'(issue_cnt), 32'd0);
        check("rst err",   32'(addr_err),  32'd0);
        step();
        rst = 1'b0;
        idle(1);

        // single op rd=5, dependent op RM=5 stalls two cycles
        offer(0, 1, 4'd0, 4'd1, 4'd2, 4'd5, 32'd7);
        @(negedge clk);
        check("t0 iss_wb", 32'(iss_wb), 32'd1);
        step();
        offer(0, 1, 4'd0, 4'd5, 4'd2, 4'd6, 32'd3);
        @(negedge clk);
        check("t1 busy",  32'(busy_mask), 32'h0020);
        check("t1 ready", 32'(req_ready), 32'd0);
        step();
        @(negedge clk);
        check("t2 busy",    32'(busy_mask), 32'h0020);
        check("t2 ready",   32'(req_ready), 32'd0);
        check("t2 wb_en",   32'(wb_en),     32'd1);
        check("t2 wb_addr", 32'(wb_addr),   32'd5);
        step();
        @(negedge clk);
        check("t3 ready", 32'(req_ready), 32'd1);
        step();
        idle(3);

        // accumulate: RN hazard stalls, same op with A=0 fires
        offer(0, 1, 4'd0, 4'd1, 4'd2, 4'd5, 32'd9);
        step();
        offer(1, 1, 4'd5, 4'd1, 4'd2, 4'd7, 32'd9);
        @(negedge clk);
        check("acc ready", 32'(req_ready), 32'd0);
        idle(3);
        offer(0, 1, 4'd0, 4'd1, 4'd2, 4'd5, 32'd9);
        step();
        offer(0, 1, 4'd5, 4'd1, 4'd2, 4'd7, 32'd9);
        @(negedge clk);
        check("noacc ready", 32'(req_ready), 32'd1);
        step();
        idle(3);

        // divide by zero
        offer(0, 1, 4'd0, 4'd1, 4'd2, 4'd9, 32'd0);
        @(negedge clk);
        check("dz iss_wb", 32'(iss_wb), 32'd0);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        check("dz fault", 32'(dz_fault),  32'd1);
        check("dz cnt",   32'(issue_cnt), 32'd6);
        step();
        @(negedge clk);
        check("dz wb_en", 32'(wb_en), 32'd0);
        idle(3);

        // two ops then flush
        offer(0, 1, 4'd0, 4'd1, 4'd2, 4'd8, 32'd5);
        step();
        offer(0, 1, 4'd0, 4'd1, 4'd2, 4'd9, 32'd5);
        step();
        flush = 1'b1;
        offer(0, 1, 4'd0, 4'd3, 4'd4, 4'd10, 32'd5);
        @(negedge clk);
        check("fl ready",   32'(req_ready), 32'd0);
        check("fl wb_en",   32'(wb_en),     32'd1);
        check("fl wb_addr", 32'(wb_addr),   32'd8);
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("fl killed wb_en", 32'(wb_en), 32'd0);
        step();
        @(negedge clk);
        check("fl no err", 32'(addr_err), 32'd0);
        idle(2);

        // back-to-back independent ops, then enough to saturate the counter
        for (int i = 0; i < 24; i++) begin
            offer(0, 1, 4'd0, 4'(8 + i % 4), 4'(12 + i % 4), 4'(i % 8), 32'(i + 1));
            @(negedge clk);
            if (i < 4) check("b2b ready", 32'(req_ready), 32'd1);
            step();
        end
        idle(3);
        @(negedge clk);
        check("sat cnt", 32'(issue_cnt), 32'd15);
        step();

        // reset in the middle of an op
        offer(0, 1, 4'd0, 4'd1, 4'd2, 4'd4, 32'd3);
        step();
        rst = 1'b1;
        req_valid = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mr busy",  32'(busy_mask), 32'd0);
        check("mr cnt",   32'(issue_cnt), 32'd0);
        check("mr wb_en", 32'(wb_en),     32'd0);
        step();
        idle(3);

        // returning address mismatch
        offer(0, 1, 4'd0, 4'd1, 4'd2, 4'd5, 32'd7);
        step();
        req_valid = 1'b0;
        step();
        ovr_en = 1'b1; ovr_wb = 1'b1; ovr_addr = 4'd3;
        @(negedge clk);
        check("ae wb_en", 32'(wb_en), 32'd1);
        step();
        ovr_en = 1'b0;
        @(negedge clk);
        check("ae set", 32'(addr_err), 32'd1);
        idle(3);
        @(negedge clk);
        check("ae sticky", 32'(addr_err), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("ae cleared", 32'(addr_err), 32'd0);
        idle(2);

        // write-back returning with no tracked op
        ovr_en = 1'b1; ovr_wb = 1'b1; ovr_addr = 4'd0;
        step();
        ovr_en = 1'b0;
        @(negedge clk);
        check("orphan err", 32'(addr_err), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        checking = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Issue and writeback controller for the 3-stage divide unit (`div_data_path`). It accepts divide micro-ops from decode over a valid/ready handshake. It stalls on read-after-write hazards against in-flight divides and suppresses issue on divide-by-zero. It tracks the datapath's fixed two-cycle latency in a slot shift register, so it can gate writeback on flush and check that the returning destination is consistent.

## Interface
Parameters:
- LAT, 2: datapath latency in clock edges from issue to result; the design is fixed at 2 and LAT is checked only.
- CNT_W, 16: width of the issue statistics counter.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- REQ_VALID  in  1  decode offers a divide micro-op
- REQ_READY  out  1  controller accepts this cycle
- REQ_A / REQ_S / REQ_WB  in  1 each  accumulate, set-flags, write-back request
- REQ_RN / REQ_RM / REQ_RS / REQ_RD  in  4 each  source and destination register addresses
- REQ_DIVISOR  in  32  Rs operand value, used for the zero check
- FLUSH  in  1  pipeline flush; kills all in-flight divides
- ISS_A / ISS_S / ISS_WB  out  1 each  control to datapath; 0 when not issuing
- ISS_RD  out  4  destination to datapath; 0 when not issuing
- DIV_WB_IN  in  1  DIV_WB returned by datapath
- DIV_ADDR_IN  in  4  DIV_Address returned by datapath
- WB_EN  out  1  gated register-file write enable
- WB_ADDR  out  4  register-file write address
- BUSY_MASK  out  16  one bit per register with a pending divide write
- DZ_FAULT  out  1  one-cycle pulse after a zero-divisor op is accepted
- ADDR_ERR  out  1  sticky; returning address mismatched the tracked slot
- ISSUE_CNT  out  CNT_W  saturating count of accepted ops

## Operation
- Fire = REQ_VALID & REQ_READY.
- REQ_READY = ~RST & ~FLUSH & ~hazard.
- Hazard: a used source matches the rd of a valid slot with wb set. Used sources are RM and RS always, plus RN when REQ_A=1. WAW does not stall, because the datapath keeps order at fixed latency.
- Issue is combinational in the fire cycle:
  - ISS_A = REQ_A and ISS_S = REQ_S.
  - ISS_RD = REQ_RD.
  - ISS_WB = REQ_WB & (REQ_DIVISOR != 0).
  - All ISS_* are 0 when not firing.
- Slot tracking:
  - slot0 <= {fire, ISS_WB, REQ_RD}.
  - slot1 <= slot0.
  - On FLUSH, both slot valid bits clear at the edge. The fire term is 0 that cycle, since REQ_READY=0.
- Writeback:
  - WB_EN = slot1.v & slot1.wb & DIV_WB_IN.
  - WB_ADDR = slot1.rd when WB_EN, else 0.
  - A flushed op returning from the datapath produces WB_EN=0.
- ADDR_ERR sets on a cycle with slot1.v & slot1.wb & DIV_WB_IN & (DIV_ADDR_IN != slot1.rd). It also sets on DIV_WB_IN=1 with slot1.v=0 while no flush occurred in the previous 2 cycles. It clears only on RST.
- BUSY_MASK = OR of one-hot(slotN.rd) over slots with v & wb.
- DZ_FAULT <= fire & (REQ_DIVISOR == 0), registered.
- ISSUE_CNT increments on fire and holds at all-ones.

## Timing
- Reset: all slot valid bits, WB_EN, WB_ADDR, DZ_FAULT, ADDR_ERR, ISSUE_CNT and BUSY_MASK are 0. REQ_READY is 0 during RST. ISS_* are 0.
- An op fired in cycle t appears at datapath output and WB_EN in cycle t+2. Its BUSY_MASK bit is set in cycles t+1 and t+2 and clears at t+3.
- A dependent op offered in cycle t+1 or t+2 stalls and fires no earlier than t+3.
- Back-to-back independent issue gives a throughput of 1 op per cycle.
- FLUSH in cycle f:
  - No accept in cycle f.
  - Slots are empty from f+1.
  - WB_EN stays 0 for datapath results in f+1..f+2 that came from pre-flush issues.
- If RST asserts mid-operation, slots clear at the edge and later datapath outputs are ignored. The datapath resets on the same RST, so these outputs are also 0.

## Structure
- A shared package holds the slot struct type {v, wb, rd[3:0]}, the register-count constant 16 and DIV_LAT=2.
- Natural sub-module: div_hazard_check, which is combinational. Its inputs are the slots, sources and REQ_A; its output is hazard.
- Top-level div_issue_ctrl holds the slots, counters and flags, and is integrated alongside div_data_path.

## Test plan
- Single op, RD=5, divisor 7, WB=1, fired at t → ISS_WB=1 at t; WB_EN=1 with WB_ADDR=5 at t+2; BUSY_MASK=0x0020 at t+1..t+2.
- Dependent op with RM=5 offered at t+1 → REQ_READY=0 at t+1 and t+2; fires at t+3.
- Accumulate op with RN=5 but RM/RS independent, offered at t+1 → stalls. The same op with A=0 → fires at t+1.
- Divisor 0, WB=1 → ISS_WB=0, DZ_FAULT=1 at t+1, WB_EN stays 0, ISSUE_CNT increments.
- Ops at t and t+1, then FLUSH at t+2 → WB_EN=1 at t+2 only. The t+1 op's result at t+3 gives WB_EN=0, and REQ_READY=0 at t+2.
- Force DIV_ADDR_IN=3 while slot1.rd=5 with DIV_WB_IN=1 → ADDR_ERR sets and stays set until RST.
